contador_bcd_modn: RTL and testbench

Parametrised synchronous BCD counter with `NUM_DIGITS` decade digits and a run-time programmable terminal value, so one module covers mod-10, mod-60 and mod-100 chains.
- Counts up or down, supports parallel load, and provides cascade outputs for chaining.
- All flip-flops share one clock; there is no ripple clocking.
- Sits in the FPGA practice designs between a tick/prescaler source and the BCD-to-7-segment decoders, for example in clock and timer displays.

---
 rtl/contador_bcd_modn.sv | 117 +++++++++++
 tb/tb_contador_bcd_modn.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_bcd_modn.sv
// contador_bcd_modn: synchronous BCD up/down counter with NUM_DIGITS decades,
// run-time terminal value (limit), parallel load with validation and cascade
// outputs. Compile-time option CONTADOR_SATURA_EN selects saturating mode
// (hold at the boundary, wrap tied low); undefined gives wrap-around mode.
module contador_bcd_modn #(
   parameter int NUM_DIGITS = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    up,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_val,
   input  logic [4*NUM_DIGITS-1:0] limit,
   output logic [4*NUM_DIGITS-1:0] q,
   output logic                    tc,
   output logic                    wrap,
   output logic                    err
);

   localparam int W = 4 * NUM_DIGITS;

   logic [W-1:0]          q_reg, q_next;
   logic                  wrap_reg, wrap_next;
   logic                  err_reg, err_next;
   logic [W-1:0]          lim_c;
   logic [W-1:0]          q_inc, q_dec;
   logic [NUM_DIGITS-1:0] carry, borrow;
   logic [NUM_DIGITS-1:0] load_digit_ok;
   logic                  q_ge_lim, q_zero, load_ok;

   // Per-digit logic: limit clamp, load digit validity, BCD increment/decrement
   // with a digit-to-digit carry/borrow chain (no binary intermediate).
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign lim_c[4*gi +: 4] = (limit[4*gi +: 4] > 4'd9) ? 4'd9 : limit[4*gi +: 4];
         assign load_digit_ok[gi] = (load_val[4*gi +: 4] <= 4'd9);

         if (gi == 0) begin : g_lsd
            assign carry[gi]  = 1'b1;
            assign borrow[gi] = 1'b1;
         end else begin : g_upper
            assign carry[gi]  = carry[gi-1]  & (q_reg[4*(gi-1) +: 4] == 4'd9);
            assign borrow[gi] = borrow[gi-1] & (q_reg[4*(gi-1) +: 4] == 4'd0);
         end

         assign q_inc[4*gi +: 4] = !carry[gi] ? q_reg[4*gi +: 4] :
                                   (q_reg[4*gi +: 4] == 4'd9) ? 4'd0 : q_reg[4*gi +: 4] + 4'd1;
         assign q_dec[4*gi +: 4] = !borrow[gi] ? q_reg[4*gi +: 4] :
                                   (q_reg[4*gi +: 4] == 4'd0) ? 4'd9 : q_reg[4*gi +: 4] - 4'd1;
      end
   endgenerate

   // Whole-vector unsigned compare of valid BCD is an MSB-first digit compare.
   assign q_ge_lim = (q_reg >= lim_c);
   assign q_zero   = (q_reg == '0);
   assign load_ok  = (&load_digit_ok) && (load_val <= lim_c);

   // Next-state selection: load has priority over count; reset is in the register.
   always_comb begin
      q_next    = q_reg;
      wrap_next = 1'b0;
      err_next  = 1'b0;
      if (load) begin
         if (load_ok) begin
            q_next = load_val;
         end else begin
            err_next = 1'b1;
         end
      end else if (en) begin
         if (up) begin
            if (q_ge_lim) begin
`ifdef CONTADOR_SATURA_EN
               q_next = lim_c;
`else
               q_next    = '0;
               wrap_next = 1'b1;
`endif
            end else begin
               q_next = q_inc;
            end
         end else begin
            if (q_zero) begin
`ifdef CONTADOR_SATURA_EN
               q_next = '0;
`else
               q_next    = lim_c;
               wrap_next = 1'b1;
`endif
            end else begin
               q_next = q_dec;
            end
         end
      end
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_reg    <= '0;
         wrap_reg <= 1'b0;
         err_reg  <= 1'b0;
      end else begin
         q_reg    <= q_next;
         wrap_reg <= wrap_next;
         err_reg  <= err_next;
      end
   end

   assign q    = q_reg;
   assign wrap = wrap_reg;
   assign err  = err_reg;
   // Terminal count is combinational so a cascaded stage advances on the same edge.
   assign tc   = en & ~load & (up ? q_ge_lim : q_zero);

endmodule

// File: tb/tb_contador_bcd_modn.sv
// Testbench for contador_bcd_modn: scoreboard of expected q/wrap/err pushed when
// stimulus is driven and popped after the edge; decimal integer reference model.
module tb_contador_bcd_modn;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b0, en = 1'b0, up = 1'b1, load = 1'b0;
   logic [7:0] load_val = 8'h00, limit = 8'h59, q;
   logic       tc, wrap, err;

   logic       c_rst = 1'b0, c_en = 1'b0;
   logic [3:0] c0_q, c1_q;
   logic       c0_tc, c1_tc, c0_wrap, c1_wrap, c0_err, c1_err;

   contador_bcd_modn #(.NUM_DIGITS(2)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_val(load_val), .limit(limit), .q(q), .tc(tc), .wrap(wrap), .err(err)
   );

   contador_bcd_modn #(.NUM_DIGITS(1)) c0 (
      .clk(clk), .rst(c_rst), .en(c_en), .up(1'b1), .load(1'b0),
      .load_val(4'h0), .limit(4'h9), .q(c0_q), .tc(c0_tc), .wrap(c0_wrap), .err(c0_err)
   );

   contador_bcd_modn #(.NUM_DIGITS(1)) c1 (
      .clk(clk), .rst(c_rst), .en(c0_tc), .up(1'b1), .load(1'b0),
      .load_val(4'h0), .limit(4'h5), .q(c1_q), .tc(c1_tc), .wrap(c1_wrap), .err(c1_err)
   );

   typedef struct {
      logic [7:0] q;
      logic       wrap;
      logic       err;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   m_q = 0;
   logic exp_tc, obs_tc;

   function automatic int dig(input logic [7:0] v, input int i);
      return int'(v[4*i +: 4]);
   endfunction

   function automatic int lim_int(input logic [7:0] l);
      int a, b;
      a = dig(l, 1);
      b = dig(l, 0);
      if (a > 9) a = 9;
      if (b > 9) b = 9;
      return a * 10 + b;
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   // Drive one cycle of stimulus, predict tc and the post-edge state, push expectation.
   task automatic drive_cycle(input logic r, input logic e, input logic u,
                              input logic l, input logic [7:0] lv);
      exp_t x;
      int   lim;
      rst = r; en = e; up = u; load = l; load_val = lv;
      #1;
      lim    = lim_int(limit);
      exp_tc = e & ~l & (u ? (m_q >= lim) : (m_q == 0));
      obs_tc = tc;
      x.wrap = 1'b0;
      x.err  = 1'b0;
      if (r) begin
         m_q = 0;
      end else if (l) begin
         if (dig(lv, 1) <= 9 && dig(lv, 0) <= 9 && (dig(lv, 1) * 10 + dig(lv, 0)) <= lim)
            m_q = dig(lv, 1) * 10 + dig(lv, 0);
         else
            x.err = 1'b1;
      end else if (e) begin
         if (u) begin
            if (m_q >= lim) begin
`ifdef CONTADOR_SATURA_EN
               m_q = lim;
`else
               m_q = 0;
               x.wrap = 1'b1;
`endif
            end else begin
               m_q = m_q + 1;
            end
         end else begin
            if (m_q == 0) begin
`ifdef CONTADOR_SATURA_EN
               m_q = 0;
`else
               m_q = lim;
               x.wrap = 1'b1;
`endif
            end else begin
               m_q = m_q - 1;
            end
         end
      end
      x.q = to_bcd(m_q);
      sb.push_back(x);
      @(posedge clk);
      #1;
      rst = 1'b0; load = 1'b0;
   endtask

   task automatic test_reset();
      exp_t x;
      drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h42);
      x = sb.pop_front();
      checks++;
      $display("reset: q=%h wrap=%b err=%b tc=%b", q, wrap, err, obs_tc);
      if ({q, wrap, err, obs_tc} !== {x.q, x.wrap, x.err, exp_tc}) begin
         failures++;
         $display("FAIL reset: got q=%h wrap=%b err=%b tc=%b, want q=%h wrap=%b err=%b tc=%b",
                  q, wrap, err, obs_tc, x.q, x.wrap, x.err, exp_tc);
      end
   endtask

   task automatic test_count_up();
      exp_t x;
      limit = 8'h59;
      for (int i = 0; i < 62; i++) begin
         drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
         x = sb.pop_front();
         checks++;
         $display("count_up[%0d]: q=%h wrap=%b tc=%b", i, q, wrap, obs_tc);
         if ({q, wrap, err, obs_tc} !== {x.q, x.wrap, x.err, exp_tc}) begin
            failures++;
            $display("FAIL count_up[%0d]: got q=%h wrap=%b err=%b tc=%b, want q=%h wrap=%b err=%b tc=%b",
                     i, q, wrap, err, obs_tc, x.q, x.wrap, x.err, exp_tc);
         end
      end
   endtask

   task automatic test_down_wrap();
      exp_t x;
      limit = 8'h59;
      for (int i = 0; i < 14; i++) begin
         if (i == 0) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
         else        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
         x = sb.pop_front();
         checks++;
         $display("down[%0d]: q=%h wrap=%b tc=%b", i, q, wrap, obs_tc);
         if ({q, wrap, err, obs_tc} !== {x.q, x.wrap, x.err, exp_tc}) begin
            failures++;
            $display("FAIL down[%0d]: got q=%h wrap=%b err=%b tc=%b, want q=%h wrap=%b err=%b tc=%b",
                     i, q, wrap, err, obs_tc, x.q, x.wrap, x.err, exp_tc);
         end
      end
   endtask

   task automatic test_load();
      exp_t       x;
      logic [7:0] vals[5];
      logic       ens[5];
      vals = '{8'h3A, 8'h75, 8'h42, 8'h15, 8'hA1};
      ens  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      limit = 8'h59;
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b0, ens[i], 1'b1, 1'b1, vals[i]);
         x = sb.pop_front();
         checks++;
         $display("load %h: q=%h err=%b", vals[i], q, err);
         if ({q, wrap, err, obs_tc} !== {x.q, x.wrap, x.err, exp_tc}) begin
            failures++;
            $display("FAIL load %h: got q=%h wrap=%b err=%b tc=%b, want q=%h wrap=%b err=%b tc=%b",
                     vals[i], q, wrap, err, obs_tc, x.q, x.wrap, x.err, exp_tc);
         end
      end
   endtask

   task automatic test_mid_events();
      exp_t x;
      for (int i = 0; i < 5; i++) begin
         limit = (i == 0) ? 8'h59 : 8'h20;
         case (i)
            0:       drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h35);
            4:       drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h12);
            default: drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
         endcase
         x = sb.pop_front();
         checks++;
         $display("mid[%0d]: q=%h wrap=%b tc=%b", i, q, wrap, obs_tc);
         if ({q, wrap, err, obs_tc} !== {x.q, x.wrap, x.err, exp_tc}) begin
            failures++;
            $display("FAIL mid[%0d]: got q=%h wrap=%b err=%b tc=%b, want q=%h wrap=%b err=%b tc=%b",
                     i, q, wrap, err, obs_tc, x.q, x.wrap, x.err, exp_tc);
         end
      end
   endtask

   task automatic test_boundaries();
      exp_t x;
      for (int i = 0; i < 20; i++) begin
         limit = (i < 16) ? 8'h05 : ((i < 18) ? 8'h00 : 8'hFC);
         if (i == 18) drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h97);
         else         drive_cycle(1'b0, 1'b1, (i < 8) || (i >= 16), 1'b0, 8'h00);
         x = sb.pop_front();
         checks++;
         $display("bound[%0d] lim=%h: q=%h wrap=%b err=%b tc=%b", i, limit, q, wrap, err, obs_tc);
         if ({q, wrap, err, obs_tc} !== {x.q, x.wrap, x.err, exp_tc}) begin
            failures++;
            $display("FAIL bound[%0d]: got q=%h wrap=%b err=%b tc=%b, want q=%h wrap=%b err=%b tc=%b",
                     i, q, wrap, err, obs_tc, x.q, x.wrap, x.err, exp_tc);
         end
      end
   endtask

   task automatic test_cascade();
      exp_t x;
      int   d0, d1;
      logic t0;
      en = 1'b0; load = 1'b0; rst = 1'b0;
      c_rst = 1'b1; c_en = 1'b0;
      @(posedge clk);
      #1;
      c_rst = 1'b0;
      d0 = 0; d1 = 0;
      checks++;
      if ({c1_q, c0_q} !== 8'h00) begin
         failures++;
         $display("FAIL cascade_reset: got %h, want 00", {c1_q, c0_q});
      end
      for (int i = 0; i < 63; i++) begin
         c_en = 1'b1;
         #1;
         t0 = (d0 >= 9);
         obs_tc = c0_tc;
`ifdef CONTADOR_SATURA_EN
         if (t0) begin if (d1 < 5) d1 = d1 + 1; end
         if (d0 < 9) d0 = d0 + 1;
`else
         if (t0) d1 = (d1 >= 5) ? 0 : d1 + 1;
         d0 = (d0 >= 9) ? 0 : d0 + 1;
`endif
         x.q = to_bcd(d1 * 10 + d0);
         x.wrap = 1'b0;
         x.err = 1'b0;
         sb.push_back(x);
         @(posedge clk);
         #1;
         x = sb.pop_front();
         checks++;
         $display("cascade[%0d]: q=%h tc0=%b", i, {c1_q, c0_q}, obs_tc);
         if ({c1_q, c0_q, obs_tc} !== {x.q, t0}) begin
            failures++;
            $display("FAIL cascade[%0d]: got q=%h tc0=%b, want q=%h tc0=%b",
                     i, {c1_q, c0_q}, obs_tc, x.q, t0);
         end
      end
      c_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_down_wrap();
      test_load();
      test_mid_events();
      test_boundaries();
      test_cascade();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
